hack_ram_arbiter: RTL and testbench
===================================

// Module: hack_ram_arbiter
// PURPOSE
//   Shares the single-port data RAM between two masters: m0 (CPU data port, priority)
//   and m1 (video scanout / loader DMA). Fixed priority to m0, with a starvation guard
//   that forces an m1 grant after MAX_WAIT consecutive denials.
//   Sits between the CPU/DMA and the RAM macro. RAM read latency is 1 cycle.
// PARAMETERS
//   AW        15  address width (words)
//   DW        16  data width
//   MAX_WAIT  4   consecutive m1 denials before m1 is forced (1..15)
// PORTS
//   clk          in   1   clock
//   reset        in   1   asynchronous, active-high
//   m0_req       in   1   m0 access request (held until granted)
//   m0_we        in   1   m0 write (1) / read (0)
//   m0_addr      in   AW  m0 address
//   m0_wdata     in   DW  m0 write data
//   m0_gnt       out  1   m0 access accepted this cycle
//   m0_rvalid    out  1   m0 read data valid (1 cycle after read grant)
//   m0_rdata     out  DW  m0 read data
//   m1_req/m1_we/m1_addr/m1_wdata   in  1/1/AW/DW  same as m0, for m1
//   m1_gnt/m1_rvalid/m1_rdata       out 1/1/DW     same as m0, for m1
//   ram_en       out  1   RAM access strobe
//   ram_we       out  1   RAM write enable
//   ram_addr     out  AW  RAM address
//   ram_wdata    out  DW  RAM write data
//   ram_rdata    in   DW  RAM read data (valid cycle after ram_en & !ram_we)
//   conflict_cnt out  16  saturating count of cycles with m0_req & m1_req
// BEHAVIOUR
//   Transfer = req & gnt in the same cycle. Grants are combinational from req, the
//   starvation counter and reset; at most one of m0_gnt/m1_gnt high per cycle.
//   Grant rule per cycle:
//     - only m0_req -> m0; only m1_req -> m1; neither -> none
//     - both, starve_cnt <  MAX_WAIT -> m0
//     - both, starve_cnt >= MAX_WAIT -> m1
//   starve_cnt (4b, reg): cleared when !m1_req or m1_gnt; else +1, saturating at MAX_WAIT.
//   RAM side (combinational): ram_en = m0_gnt|m1_gnt; ram_we/addr/wdata muxed from the
//     granted master; when no grant, ram_we=0 and ram_addr/ram_wdata = 0.
//   Read return (registered): m0_rvalid <= m0_gnt & !m0_we; m1_rvalid <= m1_gnt & !m1_we.
//     mX_rdata = ram_rdata when mX_rvalid, else 0. Latency: grant cycle N -> data cycle N+1.
//   Writes produce no rvalid; back-to-back transfers allowed every cycle.
//   Back-to-back: read granted in cycle N and another in N+1 -> rvalid in N+1 and N+2;
//     each return goes to the master that owned the grant in the previous cycle.
//   conflict_cnt: +1 each cycle m0_req & m1_req, saturates at 16'hFFFF.
//   Reset (async, any time): gnt outputs, ram_en, ram_we forced 0 while reset high;
//     rvalid 0, rdata 0, starve_cnt 0, conflict_cnt 0. A read granted in the cycle
//     reset asserts returns no rvalid. First grant possible on the cycle after
//     reset deasserts.
//   Requests/data inputs are sampled only for the current cycle; a master that
//     drops req without gnt loses nothing (no queued request state).
// TESTING
//   1 m0 read addr 0x0010 alone, RAM holds 0x1234 -> m0_gnt same cycle, m0_rvalid=1 and
//     m0_rdata=0x1234 next cycle; m1_rvalid stays 0.
//   2 m0 write 0x00AA to 0x4000 -> ram_en=1, ram_we=1, ram_addr=0x4000, ram_wdata=0x00AA,
//     no rvalid.
//   3 m0_req and m1_req both held high for 12 cycles, MAX_WAIT=4 -> grant sequence
//     m0,m0,m0,m0,m1 repeating (m1 on cycles 5 and 10); conflict_cnt=12.
//   4 alternating m0 read / m1 read on consecutive cycles -> rvalids alternate, each
//     rdata tagged to correct master, no dropped or duplicated returns.
//   5 reset pulsed in the cycle of an m1 read grant -> m1_rvalid stays 0, counters 0,
//     first grant after release obeys fixed priority (m0 if both requesting).
//   6 conflict_cnt preloaded near max via 65540 conflicting cycles -> holds 0xFFFF.

Source files
------------

// File: rtl/hack_ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: m0 has fixed priority, and m1 is
// forced through after MAX_WAIT consecutive denials. Read data returns one cycle after grant.
module hack_ram_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic [15:0]   conflict_cnt_o
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  starve_q, starve_d;
  logic [15:0] conflict_q, conflict_d;
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic        force_m1;

  // Grants are forced low while reset is high, so nothing is launched into the RAM.
  always_comb begin
    force_m1 = m1_req_i && (starve_q >= MAX_WAIT_C);
    m0_gnt_o = !reset && m0_req_i && !force_m1;
    m1_gnt_o = !reset && m1_req_i && (!m0_req_i || force_m1);
  end

  always_comb begin
    ram_en_o    = m0_gnt_o || m1_gnt_o;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (m0_gnt_o) begin
      ram_we_o    = m0_we_i;
      ram_addr_o  = m0_addr_i;
      ram_wdata_o = m0_wdata_i;
    end else if (m1_gnt_o) begin
      ram_we_o    = m1_we_i;
      ram_addr_o  = m1_addr_i;
      ram_wdata_o = m1_wdata_i;
    end
  end

  always_comb begin
    starve_d    = starve_q;
    conflict_d  = conflict_q;
    m0_rvalid_d = m0_gnt_o && !m0_we_i;
    m1_rvalid_d = m1_gnt_o && !m1_we_i;
    if (!m1_req_i || m1_gnt_o) begin
      starve_d = 4'd0;
    end else if (starve_q < MAX_WAIT_C) begin
      starve_d = starve_q + 4'd1;
    end
    if (m0_req_i && m1_req_i && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q    <= 4'd0;
      conflict_q  <= 16'd0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      conflict_q  <= conflict_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  // Return data is steered by who owned last cycle's read grant.
  assign m0_rvalid_o    = m0_rvalid_q;
  assign m1_rvalid_o    = m1_rvalid_q;
  assign m0_rdata_o     = m0_rvalid_q ? ram_rdata_i : '0;
  assign m1_rdata_o     = m1_rvalid_q ? ram_rdata_i : '0;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed bench for hack_ram_arbiter with a 1-cycle-latency RAM read model.
module tb_hack_ram_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [15:0]   conflict_cnt;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  hack_ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .conflict_cnt_o(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    #2;
    n_checks++;
    if ({m0_gnt, m1_gnt, ram_en, ram_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_gnt: got %b expected 0000", {m0_gnt, m1_gnt, ram_en, ram_we});
    end
    tick(); tick();
    n_checks++;
    if ({m0_rvalid, m1_rvalid, conflict_cnt} !== 18'd0) begin
      n_fail++; $display("FAIL reset_state: got rv %b%b cnt %h expected 00 0000", m0_rvalid, m1_rvalid, conflict_cnt);
    end
    idle();
    reset = 1'b0;
    tick();
    n_checks++;
    if (conflict_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt_after: got %h expected 0000", conflict_cnt);
    end
  endtask

  task automatic test_m0_read();
    tick();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 15'h0010;
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, ram_en, ram_we} !== 4'b1010 || ram_addr !== 15'h0010) begin
      n_fail++; $display("FAIL m0_read_gnt: got gnt/en/we %b addr %h expected 1010 0010",
                         {m0_gnt, m1_gnt, ram_en, ram_we}, ram_addr);
    end
    tick();
    idle();
    n_checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h1234 || m1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL m0_read_data: got rv %b data %h m1rv %b expected 1 1234 0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    tick();
    n_checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL m0_read_done: got rv %b data %h expected 0 0000", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_m0_write();
    tick();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 15'h4000; m0_wdata = 16'h00AA;
    #1;
    n_checks++;
    if ({m0_gnt, ram_en, ram_we} !== 3'b111 || ram_addr !== 15'h4000 || ram_wdata !== 16'h00AA) begin
      n_fail++; $display("FAIL m0_write_ram: got gnt/en/we %b addr %h wdata %h expected 111 4000 00aa",
                         {m0_gnt, ram_en, ram_we}, ram_addr, ram_wdata);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if ({m0_rvalid, m1_rvalid, ram_en, ram_we} !== 4'b0000 || ram_addr !== '0 || ram_wdata !== '0) begin
      n_fail++; $display("FAIL m0_write_idle: got rv/en/we %b addr %h wdata %h expected 0000 0000 0000",
                         {m0_rvalid, m1_rvalid, ram_en, ram_we}, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_m1;
    tick();
    m0_req = 1'b1; m0_addr = 15'h0020;
    m1_req = 1'b1; m1_addr = 15'h0030;
    for (int i = 1; i <= 12; i++) begin
      exp_m1 = (i % 5 == 0);
      #1;
      n_checks++;
      if (m0_gnt !== !exp_m1 || m1_gnt !== exp_m1 || ram_addr !== (exp_m1 ? 15'h0030 : 15'h0020)) begin
        n_fail++; $display("FAIL starve_gnt[%0d]: got m0 %b m1 %b addr %h expected m1=%b", i, m0_gnt, m1_gnt, ram_addr, exp_m1);
      end
      tick();
      if (i == 12) idle();
      n_checks++;
      if (m0_rvalid !== !exp_m1 || m1_rvalid !== exp_m1 ||
          (exp_m1 ? m1_rdata : m0_rdata) !== (exp_m1 ? 16'hB1B1 : 16'hA0A0)) begin
        n_fail++; $display("FAIL starve_ret[%0d]: got rv %b%b data %h/%h expected m1=%b", i, m0_rvalid, m1_rvalid,
                           m0_rdata, m1_rdata, exp_m1);
      end
    end
    n_checks++;
    if (conflict_cnt !== 16'd12) begin
      n_fail++; $display("FAIL starve_conflict: got %0d expected 12", conflict_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic          sel [0:3];
    logic [DW-1:0] val [0:3];
    sel[0] = 1'b0; sel[1] = 1'b1; sel[2] = 1'b0; sel[3] = 1'b1;
    val[0] = 16'hC0DE; val[1] = 16'hBEEF; val[2] = 16'hF00D; val[3] = 16'h0FF1;
    tick();
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        n_checks++;
        if (m0_rvalid !== !sel[k-1] || m1_rvalid !== sel[k-1] ||
            m0_rdata !== (sel[k-1] ? 16'h0 : val[k-1]) || m1_rdata !== (sel[k-1] ? val[k-1] : 16'h0)) begin
          n_fail++; $display("FAIL b2b_ret[%0d]: got rv %b%b data %h/%h expected sel %b data %h", k-1,
                             m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, sel[k-1], val[k-1]);
        end
      end
      idle();
      if (k < 4) begin
        if (sel[k]) begin m1_req = 1'b1; m1_addr = 15'h0040 + 15'(k); end
        else begin m0_req = 1'b1; m0_addr = 15'h0040 + 15'(k); end
        #1;
        n_checks++;
        if (m0_gnt !== !sel[k] || m1_gnt !== sel[k] || ram_addr !== 15'h0040 + 15'(k)) begin
          n_fail++; $display("FAIL b2b_gnt[%0d]: got m0 %b m1 %b addr %h expected sel %b", k, m0_gnt, m1_gnt, ram_addr, sel[k]);
        end
      end
      tick();
    end
    n_checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_tail: got rv %b%b expected 00", m0_rvalid, m1_rvalid);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    m0_req = 1'b1; m0_addr = 15'h0020;
    m1_req = 1'b1; m1_addr = 15'h0030;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
        n_fail++; $display("FAIL rst_pre_gnt[%0d]: got m0 %b m1 %b expected 1 0", i, m0_gnt, m1_gnt);
      end
      tick();
    end
    #1;
    n_checks++;
    if (m1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst_forced_m1: got %b expected 1", m1_gnt);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, ram_en, ram_we} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_gnt: got %b expected 0000", {m0_gnt, m1_gnt, ram_en, ram_we});
    end
    tick();
    n_checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== 16'h0 || m1_rdata !== 16'h0 || conflict_cnt !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_state: got rv %b%b data %h/%h cnt %h expected 00 0/0 0",
                         m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, conflict_cnt);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rst_first_gnt: got m0 %b m1 %b expected 1 0", m0_gnt, m1_gnt);
    end
    tick();
    idle();
    n_checks++;
    if (conflict_cnt !== 16'd1 || m0_rvalid !== 1'b1 || m0_rdata !== 16'hA0A0) begin
      n_fail++; $display("FAIL rst_after: got cnt %h rv %b data %h expected 0001 1 a0a0", conflict_cnt, m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_saturate();
    tick();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1;
    m1_req = 1'b1; m1_we = 1'b1;
    #1;
    n_checks++;
    if (conflict_cnt !== 16'h0) begin
      n_fail++; $display("FAIL sat_start: got %h expected 0000", conflict_cnt);
    end
    for (int n = 1; n <= 65540; n++) begin
      tick();
      if (n == 65534) begin
        n_checks++;
        if (conflict_cnt !== 16'hFFFE) begin
          n_fail++; $display("FAIL sat_fffe: got %h expected fffe", conflict_cnt);
        end
      end
      if (n == 65535 || n == 65540) begin
        n_checks++;
        if (conflict_cnt !== 16'hFFFF) begin
          n_fail++; $display("FAIL sat_ffff[%0d]: got %h expected ffff", n, conflict_cnt);
        end
      end
    end
    idle();
    tick();
    n_checks++;
    if (conflict_cnt !== 16'hFFFF || {m0_rvalid, m1_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL sat_hold: got cnt %h rv %b%b expected ffff 00", conflict_cnt, m0_rvalid, m1_rvalid);
    end
  endtask

  initial begin
    mem[15'h0010] = 16'h1234;
    mem[15'h0020] = 16'hA0A0;
    mem[15'h0030] = 16'hB1B1;
    mem[15'h0040] = 16'hC0DE;
    mem[15'h0041] = 16'hBEEF;
    mem[15'h0042] = 16'hF00D;
    mem[15'h0043] = 16'h0FF1;
    test_reset();
    test_m0_read();
    test_m0_write();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
